// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, HI/LO multiply/divide
// occupancy and taken-branch squash, plus a saturating stall-cycle counter.
module hazard_stall_unit #(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             if_id_md_start,
   input  logic             if_id_reads_hilo,
   input  logic [4:0]       id_ex_rt,
   input  logic             id_ex_mem_read,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MD_STALL = 2'd2
   } state_t;

   // The issue cycle counts as the first busy cycle, so a dependent mfhi/mflo
   // sees md_cnt==0 exactly MD_LATENCY cycles after the mult was in ID.
   localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

   state_t           r_state;
   logic [3:0]       r_md_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_load_use;
   logic w_md_busy;
   logic w_md_hazard;
   logic w_stall;
   logic w_issue;

   always_comb begin
      w_load_use  = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
      w_md_busy   = (r_md_cnt != '0);
      w_md_hazard = w_md_busy && (if_id_reads_hilo || if_id_md_start);
      w_stall     = (w_load_use || w_md_hazard) && !branch_taken && !rst;
      w_issue     = if_id_md_start && !w_stall && !branch_taken;
   end

   always_comb begin
      pc_write     = !w_stall;
      if_id_write  = !w_stall;
      id_ex_bubble = w_stall;
      if_id_flush  = branch_taken && !rst;
      id_ex_flush  = branch_taken && !rst;
      md_busy      = w_md_busy && !rst;
      stall_count  = r_stall_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_md_cnt    <= '0;
         r_stall_cnt <= '0;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_load_use && !branch_taken)
                  r_state <= LD_STALL;
               else if (w_md_hazard && !branch_taken)
                  r_state <= MD_STALL;
               else
                  r_state <= RUN;
            end
            LD_STALL: begin
               if (w_md_hazard && !branch_taken)
                  r_state <= MD_STALL;
               else
                  r_state <= RUN;
            end
            MD_STALL: begin
               if (!w_md_hazard || branch_taken)
                  r_state <= RUN;
            end
            default: r_state <= RUN;
         endcase

         // A branch flush leaves md_cnt alone: an issued op always completes.
         if (w_issue)
            r_md_cnt <= MD_LOAD;
         else if (w_md_busy)
            r_md_cnt <= r_md_cnt - 4'd1;

         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random checks of hazard_stall_unit against a cycle-indexed reference model.
module tb_hazard_stall_unit;

   localparam int unsigned MDL = 4;

   logic       clk;
   logic       rst;
   logic [4:0] if_id_rs;
   logic [4:0] if_id_rt;
   logic       if_id_uses_rt;
   logic       if_id_md_start;
   logic       if_id_reads_hilo;
   logic [4:0] id_ex_rt;
   logic       id_ex_mem_read;
   logic       branch_taken;

   logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, md_busy;
   logic [31:0] stall_count;
   logic        s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush, s_id_ex_flush, s_md_busy;
   logic [3:0]  s_stall_count;

   hazard_stall_unit #(.MD_LATENCY(MDL), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .if_id_md_start(if_id_md_start), .if_id_reads_hilo(if_id_reads_hilo),
      .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read), .branch_taken(branch_taken),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
      .stall_count(stall_count)
   );

   hazard_stall_unit #(.MD_LATENCY(MDL), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .if_id_md_start(if_id_md_start), .if_id_reads_hilo(if_id_reads_hilo),
      .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read), .branch_taken(branch_taken),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble),
      .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .md_busy(s_md_busy),
      .stall_count(s_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   int     last_issue = -1000;
   longint total = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chkc(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mds, input logic hilo,
                        input logic [4:0] ert, input logic mr, input logic bt);
      rst = r; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
      if_id_md_start = mds; if_id_reads_hilo = hilo;
      id_ex_rt = ert; id_ex_mem_read = mr; branch_taken = bt;
   endtask

   // One pipeline cycle: check outputs against the model, clock, advance the model.
   task automatic step();
      logic   lu, busy, hz, st;
      longint e32, e4;
      #2;
      lu   = id_ex_mem_read && (id_ex_rt != 5'd0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
      busy = !rst && (cyc > last_issue) && (cyc < last_issue + int'(MDL));
      hz   = busy && (if_id_reads_hilo || if_id_md_start);
      st   = !rst && !branch_taken && (lu || hz);
      e32  = (total > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : total;
      e4   = (total > 15) ? 15 : total;
      chk1("pc_write",       pc_write,       !st);
      chk1("if_id_write",    if_id_write,    !st);
      chk1("id_ex_bubble",   id_ex_bubble,   st);
      chk1("if_id_flush",    if_id_flush,    !rst && branch_taken);
      chk1("id_ex_flush",    id_ex_flush,    !rst && branch_taken);
      chk1("md_busy",        md_busy,        busy);
      chkc("stall_count",    64'(stall_count), 64'(e32));
      chk1("s_pc_write",     s_pc_write,     !st);
      chk1("s_if_id_write",  s_if_id_write,  !st);
      chk1("s_id_ex_bubble", s_id_ex_bubble, st);
      chk1("s_if_id_flush",  s_if_id_flush,  !rst && branch_taken);
      chk1("s_id_ex_flush",  s_id_ex_flush,  !rst && branch_taken);
      chk1("s_md_busy",      s_md_busy,      busy);
      chkc("s_stall_count",  64'(s_stall_count), 64'(e4));
      @(posedge clk);
      if (rst) begin
         total = 0;
         last_issue = -1000;
      end else begin
         if (st) total++;
         if (if_id_md_start && !st && !branch_taken) last_issue = cyc;
      end
      cyc++;
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      step();

      // Load-use on rs: one bubble, then released
      drive(0, 5, 0, 0, 0, 0, 5, 1, 0); step();
      drive(0, 5, 0, 0, 0, 0, 0, 0, 0); step();
      chkc("tp1_count", 64'(stall_count), 64'd1);

      // Masked load-use: rt=0, and rt match on an instruction not reading rt
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 1, 0, 0, 0, 1, 0); step();
      drive(0, 1, 7, 0, 0, 0, 7, 1, 0); step();
      drive(0, 1, 7, 1, 0, 0, 7, 1, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
      chkc("tp2_count", 64'(stall_count), 64'd1);

      // mult then mfhi: three stall cycles, released MDL cycles after issue
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
      end
      chkc("tp3_count", 64'(stall_count), 64'd3);

      // Branch beats load-use
      drive(0, 9, 0, 0, 0, 0, 9, 1, 1); step();
      chkc("tp4_count", 64'(stall_count), 64'd3);
      // Branch while mult busy: flush does not cancel the issued op
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();

      // Reset mid MD_STALL with md_cnt=2
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
      chk1("tp5_busy", md_busy, 1'b0);
      chkc("tp5_count", 64'(stall_count), 64'd0);

      // Saturation on the 4-bit counter instance
      for (int i = 0; i < 20; i++) begin
         drive(0, 3, 0, 0, 0, 0, 3, 1, 0); step();
      end
      chkc("tp6_sat", 64'(s_stall_count), 64'd15);
      chkc("tp6_wide", 64'(stall_count), 64'd20);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
